// File: rtl/display_controller_if.sv
// Display controller bus: request/control inputs from the sensor and motor
// side, and mode/digit outputs toward the 7-segment display module.
//   master : display_controller side (reads requests, drives display lines)
//   slave  : environment side (drives requests, reads display lines)
// Signals:
//   sensor_left, sensor_right, obstacle : turn/stop requests (asynchronous)
//   run, clear                          : seconds counter enable / clear
//   refresh_en                          : one-cycle strobe per ms tick
//   semnal_stanga, semnal_dreapta, stop : display mode lines
//   cifra_zeci, cifra_unitati           : BCD seconds digits
interface display_controller_if;
    logic       sensor_left;
    logic       sensor_right;
    logic       obstacle;
    logic       run;
    logic       clear;
    logic       refresh_en;
    logic       semnal_stanga;
    logic       semnal_dreapta;
    logic       stop;
    logic [3:0] cifra_zeci;
    logic [3:0] cifra_unitati;

    modport master (
        input  sensor_left, sensor_right, obstacle, run, clear,
        output refresh_en, semnal_stanga, semnal_dreapta, stop,
               cifra_zeci, cifra_unitati
    );

    modport slave (
        output sensor_left, sensor_right, obstacle, run, clear,
        input  refresh_en, semnal_stanga, semnal_dreapta, stop,
               cifra_zeci, cifra_unitati
    );
endinterface

// File: rtl/display_controller.sv
// Display sequencer for the line-follower car: arbitrates stop / turn / idle
// requests into display mode lines, generates the 1 ms refresh strobe, the
// turn-indicator blink and a 00..99 BCD seconds counter.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : display_controller_if.master (requests in, display lines out)
module display_controller #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned MS_PER_SEC = 1000,
    parameter int unsigned BLINK_MS   = 250,
    parameter int unsigned HOLD_MS    = 500
) (
    input  logic                    clock,
    input  logic                    reset_n,
    display_controller_if.master    bus
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam int unsigned MW = $clog2(MS_PER_SEC + 1);
    localparam int unsigned BW = $clog2(BLINK_MS + 1);
    localparam int unsigned HW = $clog2(HOLD_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MS_LAST    = MW'(MS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_MS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN_L = 2'd1,
        TURN_R = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync_l, sync_r, sync_o;
    logic [PW-1:0] presc, presc_n;
    logic [MW-1:0] ms_cnt;
    logic [3:0]    tens_q, units_q;
    logic [HW-1:0] hold, hold_n;
    logic [BW-1:0] blink, blink_n;
    logic          phase, phase_n;
    logic [HW-1:0] clr_cnt, clr_n;
    logic          refresh_q, left_q, right_q, stop_q;

    logic tick_c;
    logic req_l_c, req_r_c, req_o_c, same_side_c;

    // Synchronised requests; both sides at once is a line crossing, not a turn
    assign req_o_c     = sync_o[1];
    assign req_l_c     = sync_l[1] & ~sync_r[1];
    assign req_r_c     = sync_r[1] & ~sync_l[1];
    assign same_side_c = (state == TURN_L) ? req_l_c : req_r_c;

    assign tick_c  = (presc == PRESC_LAST);
    assign presc_n = tick_c ? '0 : presc + PW'(1);

    // Next-state, hold/blink and stop-clear counters
    always_comb begin
        state_n = state;
        hold_n  = hold;
        blink_n = blink;
        phase_n = phase;
        clr_n   = clr_cnt;
        case (state)
            IDLE: begin
                if (req_o_c) begin
                    state_n = STOP;
                    clr_n   = '0;
                end else if (req_l_c || req_r_c) begin
                    state_n = req_l_c ? TURN_L : TURN_R;
                    hold_n  = '0;
                    blink_n = '0;
                    phase_n = 1'b1;
                end
            end
            TURN_L, TURN_R: begin
                if (tick_c) begin
                    if (hold != HOLD_MAX) begin
                        hold_n = hold + HW'(1);
                    end
                    if (blink == BLINK_LAST) begin
                        blink_n = '0;
                        phase_n = ~phase;
                    end else begin
                        blink_n = blink + BW'(1);
                    end
                end
                if (req_o_c) begin
                    state_n = STOP;
                    clr_n   = '0;
                    hold_n  = '0;
                    blink_n = '0;
                    phase_n = 1'b0;
                end else if ((hold == HOLD_MAX) && !same_side_c) begin
                    if (req_l_c || req_r_c) begin
                        // Opposite side after the minimum hold: restart the turn
                        state_n = req_l_c ? TURN_L : TURN_R;
                        hold_n  = '0;
                        blink_n = '0;
                        phase_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = '0;
                        blink_n = '0;
                        phase_n = 1'b0;
                    end
                end
            end
            STOP: begin
                // Obstacle must stay clear for HOLD_MS consecutive ticks
                if (req_o_c) begin
                    clr_n = '0;
                end else if (clr_cnt == HOLD_MAX) begin
                    state_n = IDLE;
                    clr_n   = '0;
                end else if (tick_c) begin
                    clr_n = clr_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (outputs follow next state)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sync_l    <= '0;
            sync_r    <= '0;
            sync_o    <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            tens_q    <= '0;
            units_q   <= '0;
            hold      <= '0;
            blink     <= '0;
            phase     <= 1'b0;
            clr_cnt   <= '0;
            refresh_q <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            sync_l    <= {sync_l[0], bus.sensor_left};
            sync_r    <= {sync_r[0], bus.sensor_right};
            sync_o    <= {sync_o[0], bus.obstacle};
            presc     <= presc_n;
            state     <= state_n;
            hold      <= hold_n;
            blink     <= blink_n;
            phase     <= phase_n;
            clr_cnt   <= clr_n;
            refresh_q <= (presc_n == PRESC_LAST);
            left_q    <= (state_n == TURN_L) & phase_n;
            right_q   <= (state_n == TURN_R) & phase_n;
            stop_q    <= (state_n == STOP);

            // Seconds counter: clear wins; frozen while stopped or not running
            if (bus.clear) begin
                ms_cnt  <= '0;
                tens_q  <= '0;
                units_q <= '0;
            end else if (tick_c && bus.run && (state != STOP)) begin
                if (ms_cnt == MS_LAST) begin
                    ms_cnt <= '0;
                    if (units_q == 4'd9) begin
                        units_q <= '0;
                        tens_q  <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                    end else begin
                        units_q <= units_q + 4'd1;
                    end
                end else begin
                    ms_cnt <= ms_cnt + MW'(1);
                end
            end
        end
    end

    assign bus.refresh_en     = refresh_q;
    assign bus.semnal_stanga  = left_q;
    assign bus.semnal_dreapta = right_q;
    assign bus.stop           = stop_q;
    assign bus.cifra_zeci     = tens_q;
    assign bus.cifra_unitati  = units_q;

endmodule
